// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int STARVE_MAX_DFLT = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of i-side, d-side and memory-side signals around the arbiter.
// slave = arbiter view; master = view of the requesters plus memory.
interface mem_arbiter_if;

   logic [31:0] i_addr;
   logic        i_access;
   logic        i_ready;
   logic [31:0] i_data;

   logic [31:0] d_addr;
   logic        d_access;
   logic        d_write;
   logic [1:0]  d_size;
   logic [31:0] d_st_data;
   logic        d_ready;
   logic [31:0] d_data;

   logic [31:0] mem_a;
   logic        mem_access;
   logic        mem_write;
   logic [1:0]  mem_size;
   logic [31:0] mem_st_data;
   logic        mem_ready;
   logic [31:0] mem_data;

   modport slave (
      input  i_addr, i_access, d_addr, d_access, d_write, d_size, d_st_data,
             mem_ready, mem_data,
      output i_ready, i_data, d_ready, d_data,
             mem_a, mem_access, mem_write, mem_size, mem_st_data
   );

   modport master (
      output i_addr, i_access, d_addr, d_access, d_write, d_size, d_st_data,
             mem_ready, mem_data,
      input  i_ready, i_data, d_ready, d_data,
             mem_a, mem_access, mem_write, mem_size, mem_st_data
   );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single memory port: d-side has priority,
// but a waiting i-side wins after STARVE_MAX consecutive d-side grants.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DFLT
) (
   input  logic          aclk,
   input  logic          aresetn,
   mem_arbiter_if.slave  bus,
   output logic          grant_d
);

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   state_t      state;
   logic [3:0]  starve_cnt;
   logic [31:0] a_q;
   logic        acc_q;
   logic        we_q;
   logic [1:0]  sz_q;
   logic [31:0] st_q;
   logic        i_wins;

   assign i_wins = bus.i_access && (!bus.d_access || starve_cnt == SMAX);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= IDLE;
         starve_cnt <= '0;
         a_q        <= '0;
         acc_q      <= 1'b0;
         we_q       <= 1'b0;
         sz_q       <= '0;
         st_q       <= '0;
         grant_d    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!bus.i_access)
                  starve_cnt <= '0;
               if (i_wins) begin
                  state      <= BUSY_I;
                  acc_q      <= 1'b1;
                  a_q        <= bus.i_addr;
                  we_q       <= 1'b0;
                  sz_q       <= SZ_WORD;
                  st_q       <= '0;
                  starve_cnt <= '0;
               end else if (bus.d_access) begin
                  state   <= BUSY_D;
                  acc_q   <= 1'b1;
                  grant_d <= 1'b1;
                  a_q     <= bus.d_addr;
                  we_q    <= bus.d_write;
                  sz_q    <= bus.d_size;
                  st_q    <= bus.d_st_data;
                  // Only grants that made a waiting fetch wait count toward starvation.
                  if (bus.i_access && starve_cnt != SMAX)
                     starve_cnt <= starve_cnt + 4'd1;
               end
            end
            BUSY_I, BUSY_D: begin
               if (bus.mem_ready) begin
                  state   <= IDLE;
                  acc_q   <= 1'b0;
                  grant_d <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               acc_q   <= 1'b0;
               grant_d <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_a       = a_q;
   assign bus.mem_access  = acc_q;
   assign bus.mem_write   = we_q;
   assign bus.mem_size    = sz_q;
   assign bus.mem_st_data = st_q;

   // Ready/data are steered straight from the memory by owner so the pulse lands in the done cycle.
   assign bus.i_ready = (state == BUSY_I) && bus.mem_ready;
   assign bus.d_ready = (state == BUSY_D) && bus.mem_ready;
   assign bus.i_data  = (state == BUSY_I) ? bus.mem_data : '0;
   assign bus.d_data  = (state == BUSY_D) ? bus.mem_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected grants, memory responder, invariant monitor.
module tb_mem_arbiter;
   import mem_pkg::*;

   logic aclk;
   logic aresetn;
   logic grant_d;

   mem_arbiter_if bus();

   mem_arbiter #(.STARVE_MAX(4)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus),
      .grant_d (grant_d)
   );

   typedef struct {
      bit          is_d;
      logic [31:0] addr;
      bit          wr;
      logic [1:0]  sz;
      logic [31:0] st;
      logic [31:0] rd;
   } exp_t;

   exp_t  q[$];
   exp_t  cur;
   bit    cur_v;
   string glog;
   int    rdy_cnt;
   int    total;
   int    bad;

   bit          auto_en;
   logic        auto_rdy;
   logic        man_rdy;
   logic [31:0] man_data;
   int          wcnt;

   localparam int LAT = 3;

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      return (a == 32'hBFC0_0000) ? 32'h3C08_0001 : (a ^ 32'hA5A5_1234);
   endfunction

   assign bus.mem_ready = auto_rdy | man_rdy;
   assign bus.mem_data  = auto_rdy ? rd_model(bus.mem_a) : man_data;

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic push(input bit d, input logic [31:0] a, input bit w,
                       input logic [1:0] s, input logic [31:0] st);
      exp_t e;
      e.is_d = d; e.addr = a; e.wr = w; e.sz = s; e.st = st; e.rd = rd_model(a);
      q.push_back(e);
   endtask

   task automatic cyc;
      @(posedge aclk);
      #2;
   endtask

   task automatic wait_rdy(input string tag, input int n, input int budget);
      int tgt;
      int k;
      tgt = rdy_cnt + n;
      k = 0;
      while (rdy_cnt < tgt && k < budget) begin
         @(negedge aclk);
         #1;
         k++;
      end
      chk({tag, "_timeout"}, 32'(rdy_cnt >= tgt), 32'd1);
      cyc;
   endtask

   // Memory model: answers LAT cycles after it first sees mem_access.
   initial begin
      auto_rdy = 1'b0;
      wcnt = 0;
      forever begin
         @(posedge aclk);
         #1;
         if (auto_rdy) begin
            auto_rdy = 1'b0;
            wcnt = 0;
         end else if (auto_en && aresetn && bus.mem_access) begin
            wcnt++;
            if (wcnt >= LAT) auto_rdy = 1'b1;
         end else begin
            wcnt = 0;
         end
      end
   end

   // Monitor: grant scoreboard, ready data, exclusivity and hold-stability.
   initial begin
      logic        p_acc, p_rdy, p_we;
      logic [31:0] p_a, p_st;
      logic [1:0]  p_sz;
      p_acc = 0; p_rdy = 0; p_we = 0; p_a = '0; p_st = '0; p_sz = '0;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            cur_v = 0;
            p_acc = 0;
         end else begin
            chk("ready_excl", 32'(bus.i_ready & bus.d_ready), 32'd0);
            chk("grant_d_in_busy", 32'(grant_d & ~bus.mem_access), 32'd0);
            if (p_acc && !p_rdy && bus.mem_access) begin
               chk("hold_a",  bus.mem_a, p_a);
               chk("hold_we", 32'(bus.mem_write), 32'(p_we));
               chk("hold_sz", 32'(bus.mem_size), 32'(p_sz));
               chk("hold_st", bus.mem_st_data, p_st);
            end
            if (bus.mem_access && !p_acc) begin
               chk("grant_expected", 32'(q.size() != 0), 32'd1);
               if (q.size() != 0) begin
                  cur = q.pop_front();
                  cur_v = 1;
                  glog = {glog, grant_d ? "D" : "I"};
                  chk("g_side",  32'(grant_d), 32'(cur.is_d));
                  chk("g_addr",  bus.mem_a, cur.addr);
                  chk("g_write", 32'(bus.mem_write), 32'(cur.wr));
                  chk("g_size",  32'(bus.mem_size), 32'(cur.sz));
                  chk("g_st",    bus.mem_st_data, cur.st);
               end
            end
            if (bus.i_ready || bus.d_ready) begin
               chk("ready_has_txn", 32'(cur_v), 32'd1);
               if (cur_v) begin
                  chk("ready_side", 32'(bus.d_ready), 32'(cur.is_d));
                  chk("ready_data", bus.d_ready ? bus.d_data : bus.i_data, cur.rd);
                  cur_v = 0;
                  rdy_cnt++;
               end
            end
            p_acc = bus.mem_access; p_rdy = bus.mem_ready; p_we = bus.mem_write;
            p_a = bus.mem_a; p_sz = bus.mem_size; p_st = bus.mem_st_data;
         end
      end
   end

   initial begin
      total = 0; bad = 0; rdy_cnt = 0; glog = ""; cur_v = 0;
      auto_en = 1; man_rdy = 0; man_data = '0;
      bus.i_addr = '0; bus.i_access = 0;
      bus.d_addr = '0; bus.d_access = 0; bus.d_write = 0; bus.d_size = SZ_BYTE; bus.d_st_data = '0;
      aresetn = 0;

      // Reset state
      repeat (2) cyc;
      chk("rst_access",  32'(bus.mem_access), 32'd0);
      chk("rst_write",   32'(bus.mem_write), 32'd0);
      chk("rst_grant_d", 32'(grant_d), 32'd0);
      chk("rst_a",       bus.mem_a, 32'd0);
      chk("rst_size",    32'(bus.mem_size), 32'd0);
      chk("rst_st",      bus.mem_st_data, 32'd0);
      aresetn = 1;
      cyc;

      // Lone fetch
      push(0, 32'hBFC0_0000, 0, SZ_WORD, 32'h0);
      bus.i_addr = 32'hBFC0_0000; bus.i_access = 1;
      cyc;
      chk("t25_latency", 32'(bus.mem_access), 32'd1);
      chk("t25_size",    32'(bus.mem_size), 32'(SZ_WORD));
      wait_rdy("t25", 1, 20);
      bus.i_access = 0;
      cyc;

      // Simultaneous: d wins, i follows after one idle cycle
      push(1, 32'h8000_1000, 1, SZ_BYTE, 32'h0000_00AB);
      push(0, 32'hBFC0_0004, 0, SZ_WORD, 32'h0);
      bus.i_addr = 32'hBFC0_0004; bus.i_access = 1;
      bus.d_addr = 32'h8000_1000; bus.d_write = 1; bus.d_size = SZ_BYTE;
      bus.d_st_data = 32'h0000_00AB; bus.d_access = 1;
      cyc;
      chk("t26_grant_d", 32'(grant_d), 32'd1);
      chk("t26_write",   32'(bus.mem_write), 32'd1);
      wait_rdy("t26d", 1, 20);
      bus.d_access = 0;
      chk("t26_gap", 32'(bus.mem_access), 32'd0);
      cyc;
      chk("t26_i_start", 32'(bus.mem_access), 32'd1);
      chk("t26_i_side",  32'(grant_d), 32'd0);
      wait_rdy("t26i", 1, 20);
      bus.i_access = 0;
      cyc;

      // Both held: starvation guard forces every fifth grant to i
      glog = "";
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) push(1, 32'h8000_2000, 0, SZ_WORD, 32'h1111_2222);
         push(0, 32'hBFC0_0008, 0, SZ_WORD, 32'h0);
      end
      bus.i_addr = 32'hBFC0_0008; bus.i_access = 1;
      bus.d_addr = 32'h8000_2000; bus.d_write = 0; bus.d_size = SZ_WORD;
      bus.d_st_data = 32'h1111_2222; bus.d_access = 1;
      wait_rdy("t27", 10, 200);
      bus.i_access = 0; bus.d_access = 0;
      total++;
      assert (glog == "DDDDIDDDDI") else begin
         bad++;
         $error("FAIL t27_sequence observed=%s expected=DDDDIDDDDI", glog);
      end
      cyc;

      // Reset mid BUSY_D with mem_ready arriving inside reset
      auto_en = 0;
      push(1, 32'h8000_3000, 0, SZ_HALF, 32'h0);
      push(1, 32'h8000_3000, 0, SZ_HALF, 32'h0);
      bus.d_addr = 32'h8000_3000; bus.d_write = 0; bus.d_size = SZ_HALF;
      bus.d_st_data = 32'h0; bus.d_access = 1;
      cyc;
      chk("t28_grant", 32'(grant_d), 32'd1);
      cyc;
      cyc;
      aresetn = 0;
      man_rdy = 1; man_data = 32'h1234_5678;
      #1;
      chk("t28_d_ready", 32'(bus.d_ready), 32'd0);
      chk("t28_i_ready", 32'(bus.i_ready), 32'd0);
      chk("t28_access",  32'(bus.mem_access), 32'd0);
      chk("t28_write",   32'(bus.mem_write), 32'd0);
      chk("t28_grant_d", 32'(grant_d), 32'd0);
      chk("t28_a",       bus.mem_a, 32'd0);
      chk("t28_size",    32'(bus.mem_size), 32'd0);
      chk("t28_st",      bus.mem_st_data, 32'd0);
      cyc;
      chk("t28_d_ready_clk", 32'(bus.d_ready), 32'd0);
      chk("t28_access_clk",  32'(bus.mem_access), 32'd0);
      man_rdy = 0;
      aresetn = 1;
      auto_en = 1;
      cyc;
      chk("t28_regrant", 32'(bus.mem_access), 32'd1);
      chk("t28_regrant_d", 32'(grant_d), 32'd1);
      wait_rdy("t28", 1, 20);
      bus.d_access = 0;
      cyc;

      // Stray mem_ready in IDLE
      man_rdy = 1; man_data = 32'hDEAD_BEEF;
      #1;
      chk("t29_i_ready", 32'(bus.i_ready), 32'd0);
      chk("t29_d_ready", 32'(bus.d_ready), 32'd0);
      cyc;
      man_rdy = 0;
      chk("t29_idle_access", 32'(bus.mem_access), 32'd0);
      chk("t29_idle_grant",  32'(grant_d), 32'd0);

      // Half-word store still arbitrates normally afterwards
      push(1, 32'h8000_4002, 1, SZ_HALF, 32'h1234_5678);
      bus.d_addr = 32'h8000_4002; bus.d_write = 1; bus.d_size = SZ_HALF;
      bus.d_st_data = 32'h1234_5678; bus.d_access = 1;
      wait_rdy("t29_store", 1, 20);
      bus.d_access = 0;
      cyc;

      chk("sb_empty", 32'(q.size()), 32'd0);
      chk("ready_total", 32'(rdy_cnt), 32'd15);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
